// File: rtl/multicycle_controller_if.sv
// Handshake bundle between the multicycle controller and its datapath.
// The controller side uses the master modport: it reads the decoded
// instruction and memory status and drives every datapath control.
interface multicycle_controller_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] instruction;
  logic [7:0]       instructionOp;
  logic             memReady;

  logic [3:0]       ALUOp;
  logic [1:0]       shiftOp;
  logic [2:0]       busOp;
  logic             fetchPhase;
  logic             immMUX;
  logic             regWrite;
  logic             memWrite;
  logic             flagWrite;
  logic             LUIOp;
  logic             pcAdd;
  logic             pcJump;
  logic             pcBranch;
  logic             memReq;
  logic             illegalOp;
  logic [3:0]       state;

  modport master (
    input  instruction, instructionOp, memReady,
    output ALUOp, shiftOp, busOp, fetchPhase, immMUX, regWrite, memWrite,
           flagWrite, LUIOp, pcAdd, pcJump, pcBranch, memReq, illegalOp, state
  );

  modport slave (
    output instruction, instructionOp, memReady,
    input  ALUOp, shiftOp, busOp, fetchPhase, immMUX, regWrite, memWrite,
           flagWrite, LUIOp, pcAdd, pcJump, pcBranch, memReq, illegalOp, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle instruction controller: steps each instruction through fetch,
// decode and one or more execute states, driving registered datapath
// controls. The only combinational output term is the store-completion
// pcAdd, which depends on memReady in the same cycle.
module multicycle_controller #(
  parameter int WIDTH        = 16,
  parameter int MEM_WAIT     = 1,
  parameter bit EN_MEM_READY = 1'b0
) (
  input logic                    clk,
  input logic                    reset,
  multicycle_controller_if.master ctl
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    RTYPE   = 4'd2,
    ITYPE   = 4'd3,
    SHIFT   = 4'd4,
    LUI1    = 4'd5,
    LUI2    = 4'd6,
    LDWAIT  = 4'd7,
    LDWB    = 4'd8,
    STWR    = 4'd9,
    STWAIT  = 4'd10,
    JAL     = 4'd11,
    JCOND   = 4'd12,
    BCOND   = 4'd13,
    ILLEGAL = 4'd14
  } state_t;

  typedef struct packed {
    logic [3:0] aluOp;
    logic [2:0] busOp;
    logic       fetchPhase;
    logic       immMUX;
    logic       regWrite;
    logic       memWrite;
    logic       flagWrite;
    logic       luiOp;
    logic       pcAdd;
    logic       pcJump;
    logic       pcBranch;
    logic       memReq;
    logic       illegalOp;
  } ctrl_t;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [7:0]       r_op;
  ctrl_t            r_out;

  state_t           w_nextState;
  logic [3:0]       w_nextCnt;
  logic [7:0]       w_opSel;
  logic             w_ready;
  logic             w_waitDone;
  logic             w_storeExit;
  ctrl_t            w_nextOut;
  logic [WIDTH-1:0] w_unusedInstr;

  // Opcode-to-first-execute-state mapping used in DECODE.
  function automatic state_t decodeOp(input logic [7:0] op);
    state_t s;
    case (op)
      8'h05, 8'h09, 8'h01, 8'h02, 8'h03, 8'h0B, 8'h0D, 8'h0E: s = RTYPE;
      8'h50, 8'h90, 8'h10, 8'h20, 8'h30, 8'hB0, 8'hD0, 8'hE0: s = ITYPE;
      8'h84, 8'h80, 8'h81:                                    s = SHIFT;
      8'hF0:                                                  s = LUI1;
      8'h40:                                                  s = LDWAIT;
      8'h44:                                                  s = STWR;
      8'h48:                                                  s = JAL;
      8'h4C:                                                  s = JCOND;
      8'hC0:                                                  s = BCOND;
      default:                                                s = ILLEGAL;
    endcase
    return s;
  endfunction

  // Control word for a state; ALU states pick the operation from the
  // register-form low nibble or the immediate-form high nibble.
  function automatic ctrl_t stateOutputs(input state_t s, input logic [7:0] op);
    ctrl_t      o;
    logic [3:0] fn;
    o  = '0;
    fn = (s == ITYPE) ? op[7:4] : op[3:0];
    case (s)
      FETCH: o.fetchPhase = 1'b1;
      RTYPE, ITYPE: begin
        o.regWrite = 1'b1;
        o.pcAdd    = 1'b1;
        o.immMUX   = (s == ITYPE);
        case (fn)
          4'h5: o.flagWrite = 1'b1;
          4'h9: begin o.aluOp = 4'd8; o.flagWrite = 1'b1; end
          4'h1: begin o.aluOp = 4'd1; o.flagWrite = 1'b1; end
          4'h2: begin o.aluOp = 4'd2; o.flagWrite = 1'b1; end
          4'h3: begin o.aluOp = 4'd3; o.flagWrite = 1'b1; end
          4'hB: begin o.aluOp = 4'd8; o.flagWrite = 1'b1; o.regWrite = 1'b0; end
          4'hD: o.aluOp = 4'd4;
          4'hE: o.busOp = 3'd2;
          default: o.aluOp = 4'd0;
        endcase
      end
      SHIFT: begin
        o.busOp    = 3'd1;
        o.regWrite = 1'b1;
        o.pcAdd    = 1'b1;
        o.immMUX   = (op != 8'h84);
      end
      LUI1: begin
        o.immMUX   = 1'b1;
        o.busOp    = 3'd2;
        o.regWrite = 1'b1;
      end
      LUI2: begin
        o.luiOp    = 1'b1;
        o.immMUX   = 1'b1;
        o.busOp    = 3'd1;
        o.regWrite = 1'b1;
        o.pcAdd    = 1'b1;
      end
      LDWAIT: o.memReq = 1'b1;
      LDWB: begin
        o.busOp    = 3'd3;
        o.regWrite = 1'b1;
        o.pcAdd    = 1'b1;
      end
      STWR: begin
        o.busOp    = 3'd5;
        o.memWrite = 1'b1;
        o.memReq   = 1'b1;
      end
      STWAIT: o.memReq = 1'b1;
      JAL: begin
        o.regWrite = 1'b1;
        o.pcAdd    = 1'b1;
        o.busOp    = 3'd4;
      end
      JCOND: o.pcJump = 1'b1;
      BCOND: begin
        o.pcBranch = 1'b1;
        o.immMUX   = 1'b1;
      end
      ILLEGAL: begin
        o.illegalOp = 1'b1;
        o.pcAdd     = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  // Next state, wait counter and the control word the next state will present.
  always_comb begin
    w_opSel    = (r_state == DECODE) ? ctl.instructionOp : r_op;
    w_ready    = !EN_MEM_READY || ctl.memReady;
    w_waitDone = (r_cnt == 4'd0) && w_ready;

    w_nextState = FETCH;
    case (r_state)
      FETCH:   w_nextState = DECODE;
      DECODE:  w_nextState = decodeOp(ctl.instructionOp);
      LUI1:    w_nextState = LUI2;
      JAL:     w_nextState = JCOND;
      STWR:    w_nextState = STWAIT;
      LDWAIT:  w_nextState = w_waitDone ? LDWB : LDWAIT;
      STWAIT:  w_nextState = w_waitDone ? FETCH : STWAIT;
      default: w_nextState = FETCH;
    endcase

    if ((r_state == LDWAIT) || (r_state == STWAIT)) begin
      w_nextCnt = (r_cnt == 4'd0) ? 4'd0 : (r_cnt - 4'd1);
    end else if ((w_nextState == LDWAIT) || (w_nextState == STWAIT)) begin
      w_nextCnt = 4'(MEM_WAIT);
    end else begin
      w_nextCnt = r_cnt;
    end

    w_nextOut = stateOutputs(w_nextState, w_opSel);
  end

  // State, counter, latched opcode and registered controls; reset aborts anything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
      r_cnt   <= 4'd0;
      r_op    <= 8'd0;
      r_out   <= stateOutputs(FETCH, 8'd0);
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_op    <= w_opSel;
      r_out   <= w_nextOut;
    end
  end

  assign w_storeExit   = (r_state == STWAIT) && w_waitDone && !reset;
  assign w_unusedInstr = ctl.instruction;

  assign ctl.ALUOp      = r_out.aluOp;
  assign ctl.shiftOp    = 2'b00;
  assign ctl.busOp      = r_out.busOp;
  assign ctl.fetchPhase = r_out.fetchPhase;
  assign ctl.immMUX     = r_out.immMUX;
  assign ctl.regWrite   = r_out.regWrite;
  assign ctl.memWrite   = r_out.memWrite;
  assign ctl.flagWrite  = r_out.flagWrite;
  assign ctl.LUIOp      = r_out.luiOp;
  assign ctl.pcAdd      = r_out.pcAdd | w_storeExit;
  assign ctl.pcJump     = r_out.pcJump;
  assign ctl.pcBranch   = r_out.pcBranch;
  assign ctl.memReq     = r_out.memReq;
  assign ctl.illegalOp  = r_out.illegalOp;
  assign ctl.state      = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller. Two instances: A has a fixed
// three-cycle memory wait with memReady ignored, B has no fixed wait but
// waits for memReady. Each instruction is turned into an expected
// per-cycle trace of (state, controls) by a model written from the
// instruction semantics, then replayed against the DUT.
module tb_multicycle_controller;

  localparam logic [10:0] F_FETCH  = 11'b100_0000_0000;
  localparam logic [10:0] F_IMM    = 11'b010_0000_0000;
  localparam logic [10:0] F_REG    = 11'b001_0000_0000;
  localparam logic [10:0] F_MEMW   = 11'b000_1000_0000;
  localparam logic [10:0] F_FLAG   = 11'b000_0100_0000;
  localparam logic [10:0] F_LUI    = 11'b000_0010_0000;
  localparam logic [10:0] F_PCADD  = 11'b000_0001_0000;
  localparam logic [10:0] F_JUMP   = 11'b000_0000_1000;
  localparam logic [10:0] F_BR     = 11'b000_0000_0100;
  localparam logic [10:0] F_MEMREQ = 11'b000_0000_0010;
  localparam logic [10:0] F_ILL    = 11'b000_0000_0001;
  localparam logic [10:0] F_NONE   = 11'b000_0000_0000;

  localparam int RM_RAND = 0;
  localparam int RM_LOW  = 1;
  localparam int RM_HIGH = 2;

  typedef struct {
    logic [23:0] exp;
    bit          driveOp;
    int          readyMode;
  } step_t;

  logic clk;
  logic resetA;
  logic resetB;
  int   testsRun;
  int   testsFailed;
  step_t trace[$];

  logic [7:0] legalOps [25] = '{
    8'h05, 8'h09, 8'h01, 8'h02, 8'h03, 8'h0B, 8'h0D, 8'h0E,
    8'h50, 8'h90, 8'h10, 8'h20, 8'h30, 8'hB0, 8'hD0, 8'hE0,
    8'h84, 8'h80, 8'h81, 8'hF0, 8'h40, 8'h44, 8'h48, 8'h4C, 8'hC0
  };

  multicycle_controller_if #(.WIDTH(16)) ifA ();
  multicycle_controller_if #(.WIDTH(16)) ifB ();

  multicycle_controller #(.WIDTH(16), .MEM_WAIT(3), .EN_MEM_READY(1'b0)) dutA (
    .clk  (clk),
    .reset(resetA),
    .ctl  (ifA)
  );

  multicycle_controller #(.WIDTH(16), .MEM_WAIT(0), .EN_MEM_READY(1'b1)) dutB (
    .clk  (clk),
    .reset(resetB),
    .ctl  (ifB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] ow(input int st, input int alu, input int bus, input logic [10:0] fl);
    return {4'(st), 4'(alu), 2'b00, 3'(bus), fl};
  endfunction

  function automatic logic [23:0] observe(input int sel);
    if (sel == 0)
      return {ifA.state, ifA.ALUOp, ifA.shiftOp, ifA.busOp, ifA.fetchPhase, ifA.immMUX,
              ifA.regWrite, ifA.memWrite, ifA.flagWrite, ifA.LUIOp, ifA.pcAdd,
              ifA.pcJump, ifA.pcBranch, ifA.memReq, ifA.illegalOp};
    return {ifB.state, ifB.ALUOp, ifB.shiftOp, ifB.busOp, ifB.fetchPhase, ifB.immMUX,
            ifB.regWrite, ifB.memWrite, ifB.flagWrite, ifB.LUIOp, ifB.pcAdd,
            ifB.pcJump, ifB.pcBranch, ifB.memReq, ifB.illegalOp};
  endfunction

  task automatic addStep(input logic [23:0] e, input bit d, input int rm);
    step_t s;
    s.exp       = e;
    s.driveOp   = d;
    s.readyMode = rm;
    trace.push_back(s);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, starting in FETCH.
  task automatic buildTrace(input int sel, input logic [7:0] op, input int delay);
    int          memWait;
    bit          en;
    int          nWait;
    int          alu;
    int          bus;
    bit          flag;
    bit          rw;
    bit          isR;
    bit          isI;
    logic [10:0] fl;
    memWait = (sel == 0) ? 3 : 0;
    en      = (sel != 0);
    nWait   = (en ? ((delay > memWait) ? delay : memWait) : memWait) + 1;
    alu = 0; bus = 0; flag = 1'b0; rw = 1'b1;
    isR = op inside {8'h05, 8'h09, 8'h01, 8'h02, 8'h03, 8'h0B, 8'h0D, 8'h0E};
    isI = op inside {8'h50, 8'h90, 8'h10, 8'h20, 8'h30, 8'hB0, 8'hD0, 8'hE0};
    case (op)
      8'h05, 8'h50: flag = 1'b1;
      8'h09, 8'h90: begin alu = 8; flag = 1'b1; end
      8'h01, 8'h10: begin alu = 1; flag = 1'b1; end
      8'h02, 8'h20: begin alu = 2; flag = 1'b1; end
      8'h03, 8'h30: begin alu = 3; flag = 1'b1; end
      8'h0B, 8'hB0: begin alu = 8; flag = 1'b1; rw = 1'b0; end
      8'h0D, 8'hD0: alu = 4;
      8'h0E, 8'hE0: bus = 2;
      default: alu = 0;
    endcase
    trace.delete();
    addStep(ow(0, 0, 0, F_FETCH), 1'b0, RM_RAND);
    addStep(ow(1, 0, 0, F_NONE), 1'b1, RM_RAND);
    if (isR || isI) begin
      fl = F_PCADD | (rw ? F_REG : F_NONE) | (flag ? F_FLAG : F_NONE) | (isI ? F_IMM : F_NONE);
      addStep(ow(isI ? 3 : 2, alu, bus, fl), 1'b0, RM_RAND);
    end else begin
      case (op)
        8'h84, 8'h80, 8'h81:
          addStep(ow(4, 0, 1, F_REG | F_PCADD | ((op == 8'h84) ? F_NONE : F_IMM)), 1'b0, RM_RAND);
        8'hF0: begin
          addStep(ow(5, 0, 2, F_IMM | F_REG), 1'b0, RM_RAND);
          addStep(ow(6, 0, 1, F_LUI | F_IMM | F_REG | F_PCADD), 1'b0, RM_RAND);
        end
        8'h40: begin
          for (int k = 0; k < nWait; k++)
            addStep(ow(7, 0, 0, F_MEMREQ), 1'b0, en ? ((k >= delay) ? RM_HIGH : RM_LOW) : RM_RAND);
          addStep(ow(8, 0, 3, F_REG | F_PCADD), 1'b0, RM_RAND);
        end
        8'h44: begin
          addStep(ow(9, 0, 5, F_MEMW | F_MEMREQ), 1'b0, RM_RAND);
          for (int k = 0; k < nWait; k++)
            addStep(ow(10, 0, 0, F_MEMREQ | ((k == nWait - 1) ? F_PCADD : F_NONE)), 1'b0,
                    en ? ((k >= delay) ? RM_HIGH : RM_LOW) : RM_RAND);
        end
        8'h48: begin
          addStep(ow(11, 0, 4, F_REG | F_PCADD), 1'b0, RM_RAND);
          addStep(ow(12, 0, 0, F_JUMP), 1'b0, RM_RAND);
        end
        8'h4C: addStep(ow(12, 0, 0, F_JUMP), 1'b0, RM_RAND);
        8'hC0: addStep(ow(13, 0, 0, F_BR | F_IMM), 1'b0, RM_RAND);
        default: addStep(ow(14, 0, 0, F_ILL | F_PCADD), 1'b0, RM_RAND);
      endcase
    end
  endtask

  task automatic applyStimulus(input int sel, input logic [7:0] op, input int rm);
    bit rdy;
    rdy = (rm == RM_RAND) ? bit'($urandom % 2) : (rm == RM_HIGH);
    if (sel == 0) begin
      ifA.instructionOp = op;
      ifA.instruction   = 16'($urandom);
      ifA.memReady      = rdy;
    end else begin
      ifB.instructionOp = op;
      ifB.instruction   = 16'($urandom);
      ifB.memReady      = rdy;
    end
  endtask

  task automatic checkOutput(input int sel, input logic [23:0] exp, input string tag);
    logic [23:0] obs;
    obs = observe(sel);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed state=%0d word=%h, expected state=%0d word=%h",
             tag, obs[23:20], obs, exp[23:20], exp);
    end
  endtask

  task automatic setReset(input int sel, input logic v);
    if (sel == 0) resetA = v;
    else          resetB = v;
  endtask

  // Runs the first 'limit' cycles of an instruction (all of it when limit < 0).
  task automatic runSteps(input int sel, input logic [7:0] op, input int delay,
                          input int limit, input string tag);
    int n;
    buildTrace(sel, op, delay);
    n = (limit < 0 || limit > trace.size()) ? trace.size() : limit;
    for (int k = 0; k < n; k++) begin
      applyStimulus(sel, trace[k].driveOp ? op : 8'($urandom), trace[k].readyMode);
      @(negedge clk);
      checkOutput(sel, trace[k].exp, $sformatf("%s op=%h step%0d", tag, op, k));
      @(posedge clk);
      #1;
    end
  endtask

  // Asserts reset during cycle k of an instruction and checks the abort.
  task automatic abortAt(input int sel, input logic [7:0] op, input int delay,
                         input int k, input string tag);
    logic [23:0] exp;
    runSteps(sel, op, delay, k, tag);
    applyStimulus(sel, 8'($urandom), trace[k].readyMode);
    setReset(sel, 1'b1);
    exp = trace[k].exp;
    if (exp[23:20] == 4'd10) exp[4] = 1'b0;
    @(negedge clk);
    checkOutput(sel, exp, {tag, " preEdge"});
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      applyStimulus(sel, 8'($urandom), RM_RAND);
      @(negedge clk);
      checkOutput(sel, ow(0, 0, 0, F_FETCH), $sformatf("%s inReset%0d", tag, i));
    end
    @(posedge clk);
    #1;
    setReset(sel, 1'b0);
  endtask

  function automatic logic [7:0] randOp();
    if ($urandom_range(0, 3) != 0) return legalOps[$urandom_range(0, 24)];
    return 8'($urandom);
  endfunction

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    resetA      = 1'b1;
    resetB      = 1'b1;
    applyStimulus(0, 8'h00, RM_LOW);
    applyStimulus(1, 8'h00, RM_LOW);

    @(posedge clk);
    #1;
    applyStimulus(0, 8'($urandom), RM_RAND);
    applyStimulus(1, 8'($urandom), RM_RAND);
    @(negedge clk);
    checkOutput(0, ow(0, 0, 0, F_FETCH), "resetA");
    checkOutput(1, ow(0, 0, 0, F_FETCH), "resetB");
    @(posedge clk);
    #1;
    resetA = 1'b0;

    runSteps(0, 8'h05, 0, -1, "ADD");
    runSteps(0, 8'hB0, 0, -1, "CMPI");
    runSteps(0, 8'h0B, 0, -1, "CMP");
    runSteps(0, 8'h40, 0, -1, "LOAD");
    runSteps(0, 8'h44, 0, -1, "STORE_A");
    runSteps(0, 8'h77, 0, -1, "ILLEGAL");
    runSteps(0, 8'hF0, 0, -1, "LUI");
    runSteps(0, 8'h48, 0, -1, "JAL");
    runSteps(0, 8'h4C, 0, -1, "JCOND");
    runSteps(0, 8'hC0, 0, -1, "BCOND");
    runSteps(0, 8'h84, 0, -1, "SHIFTR");
    runSteps(0, 8'h81, 0, -1, "SHIFTI");
    runSteps(0, 8'hE0, 0, -1, "MOVI");
    runSteps(0, 8'h0D, 0, -1, "MUL");
    abortAt(0, 8'h48, 0, 2, "jalReset");
    abortAt(0, 8'h40, 0, 3, "ldReset");
    repeat (40) runSteps(0, randOp(), 0, -1, "randA");

    resetA = 1'b1;
    resetB = 1'b0;
    runSteps(1, 8'h44, 5, -1, "STORE_ready");
    runSteps(1, 8'h44, 0, -1, "STORE_fast");
    runSteps(1, 8'h40, 2, -1, "LOAD_ready");
    runSteps(1, 8'h40, 0, -1, "LOAD_fast");
    abortAt(1, 8'h44, 0, 3, "stReset");
    repeat (40) runSteps(1, randOp(), $urandom_range(0, 4), -1, "randB");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 16, instruction word width.
REQ-002 SHALL have parameter MEM_WAIT, default 1, range 0..15, fixed wait cycles per memory access.
REQ-003 SHALL have parameter EN_MEM_READY, default 0; when 1, a memory access also waits for memReady.
REQ-004 SHALL have ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- instruction  in  WIDTH  current instruction word, unused internally
- instructionOp  in  8  decoded opcode
- memReady  in  1  memory completion; ignored when EN_MEM_READY=0
- ALUOp  out  4  ALU operation
- shiftOp  out  2  shifter operation, always 0
- busOp  out  3  writeback bus select
- fetchPhase, immMUX, regWrite, memWrite, flagWrite, LUIOp  out  1 each  datapath controls
- pcAdd, pcJump, pcBranch  out  1 each  PC update controls
- memReq  out  1  memory access in progress
- illegalOp  out  1  one-cycle pulse for an unknown opcode
- state  out  4  current state code, for debug

Function
REQ-005 SHALL use state codes FETCH=0, DECODE=1, RTYPE=2, ITYPE=3, SHIFT=4, LUI1=5, LUI2=6, LDWAIT=7, LDWB=8, STWR=9, STWAIT=10, JAL=11, JCOND=12, BCOND=13, ILLEGAL=14; code 15 SHALL go to FETCH.
REQ-006 SHALL decode in DECODE, based on instructionOp:
- RTYPE for 05,09,01,02,03,0B,0D,0E
- ITYPE for 50,90,10,20,30,B0,D0,E0
- SHIFT for 84,80,81
- LUI1 for F0
- LDWAIT for 40
- STWR for 44
- JAL for 48
- JCOND for 4C
- BCOND for C0
- ILLEGAL for any other value
REQ-007 SHALL follow these transitions:
- FETCH->DECODE
- LUI1->LUI2
- JAL->JCOND
- STWR->STWAIT
- RTYPE, ITYPE, SHIFT, LUI2, LDWB, JCOND, BCOND, ILLEGAL->FETCH
REQ-008 SHALL reload a 4-bit wait counter with MEM_WAIT when entering LDWAIT or STWAIT, and decrement it each cycle spent in those states.
REQ-009 SHALL leave LDWAIT (to LDWB) or STWAIT (to FETCH) when the counter is 0 and (memReady or EN_MEM_READY=0); MEM_WAIT=0 gives one cycle in the wait state.
REQ-010 SHALL default every output to 0 each cycle; only the listed outputs are asserted.
REQ-011 FETCH SHALL assert fetchPhase; DECODE SHALL assert nothing.
REQ-012 RTYPE/ITYPE SHALL assert regWrite and pcAdd; ITYPE SHALL also assert immMUX.
REQ-013 RTYPE/ITYPE SHALL drive ALUOp and flags per operation:
- ADD/ADDI: ALUOp 0, flagWrite
- SUB/SUBI: ALUOp 8, flagWrite
- AND/ANDI: ALUOp 1, flagWrite
- OR/ORI: ALUOp 2, flagWrite
- XOR/XORI: ALUOp 3, flagWrite
- CMP/CMPI: ALUOp 8, flagWrite, regWrite=0
- MUL/MULI: ALUOp 4, no flagWrite
- MOV/MOVI: ALUOp 0, busOp 2
REQ-014 SHIFT SHALL assert busOp=1, regWrite and pcAdd; immMUX SHALL be 1 for 80/81 and 0 for 84.
REQ-015 LUI1 SHALL assert immMUX, busOp=2 and regWrite; LUI2 SHALL assert LUIOp, immMUX, busOp=1, regWrite and pcAdd.
REQ-016 LDWAIT SHALL assert memReq; LDWB SHALL assert busOp=3, regWrite and pcAdd.
REQ-017 STWR SHALL assert busOp=5, memWrite and memReq; STWAIT SHALL assert memReq, plus pcAdd on its exit cycle only.
REQ-018 JAL SHALL assert regWrite, pcAdd and busOp=4; JCOND SHALL assert pcJump; BCOND SHALL assert pcBranch and immMUX.
REQ-019 ILLEGAL SHALL assert illegalOp and pcAdd for exactly one cycle.
REQ-020 pcAdd, pcJump and pcBranch SHALL assert at most once per instruction, and never together.
REQ-021 instructionOp SHALL be sampled only in DECODE; in every other state, RTYPE/ITYPE/SHIFT output selection SHALL use the opcode latched in DECODE.

Reset
REQ-022 When reset=1 at a rising edge, the next state SHALL be FETCH and the wait counter and latched opcode SHALL be 0, from any state.
REQ-023 While in reset, outputs SHALL equal the FETCH values (fetchPhase=1, all others 0, state=0).
REQ-024 Reset asserted during LDWAIT or STWAIT SHALL abort the access; memReq SHALL drop the cycle after the reset edge, with no pcAdd.

Verification
REQ-025 ADD (05) -> states 0,1,2,0; in RTYPE ALUOp=0, regWrite=1, flagWrite=1, pcAdd=1.
REQ-026 CMPI (B0) -> in ITYPE immMUX=1, ALUOp=8, flagWrite=1, regWrite=0.
REQ-027 LOAD, MEM_WAIT=3, EN_MEM_READY=0 -> states 0,1,7,7,7,7,8,0; memReq=1 for 4 cycles; pcAdd=1 only in LDWB.
REQ-028 STOR, MEM_WAIT=0, EN_MEM_READY=1, memReady held low 5 cycles -> remains in STWAIT until memReady=1, then pcAdd=1 once and returns to FETCH.
REQ-029 Opcode 77 -> states 0,1,14,0; illegalOp one-cycle pulse, pcAdd=1.
REQ-030 JAL (48), reset asserted in JAL -> no JCOND, state=0 next cycle; also check LUI (F0) sequence 5,6 with LUIOp=1 only in LUI2.
